// File: rtl/joy_pkg.sv
// Shared types and constants for the DB15 joystick scanner.
package joy_pkg;

    typedef enum logic [2:0] {
        StLoad,
        StShiftLo,
        StShiftHi,
        StDone,
        StGap
    } state_e;

    localparam int unsigned P1_BASE  = 0;
    localparam int unsigned P2_BASE  = 12;
    localparam int unsigned PAD_BITS = 12;

    // Extracts one 12-bit pad field from the zero-extended raw frame.
    function automatic logic [15:0] pad_word(input logic [31:0] raw, input int unsigned base);
        return 16'(raw[base +: PAD_BITS]);
    endfunction

endpackage

// File: rtl/joy_db15_scan_if.sv
// Adapter-side serial lines plus the decoded pad outputs of the scanner.
interface joy_db15_scan_if;

    logic        joy_data;
    logic        joy_clk;
    logic        joy_load;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        present;
    logic        frame_strobe;

    modport master (
        input  joy_data,
        output joy_clk,
        output joy_load,
        output joystick1,
        output joystick2,
        output present,
        output frame_strobe
    );

    modport slave (
        output joy_data,
        input  joy_clk,
        input  joy_load,
        input  joystick1,
        input  joystick2,
        input  present,
        input  frame_strobe
    );

endinterface

// File: rtl/joy_tick_gen.sv
// Free-running divider: tick_o is high for one clk every CLK_DIV clks.
module joy_tick_gen #(
    parameter int unsigned CLK_DIV = 24
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(CLK_DIV);

    logic [CntW-1:0] cnt_q;

    assign tick_o = (cnt_q == CntW'(CLK_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/joy_db15_scan.sv
// 74HC165-chain scanner for the DB15 UserIO adapter: load, shift, plausibility check and
// two-frame filter producing active-high pad words for two players.
module joy_db15_scan
    import joy_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 24,
    parameter int unsigned FRAME_BITS = 24,
    parameter int unsigned GAP_TICKS  = 64,
    parameter int unsigned FILTER     = 1
) (
    input  logic            clk,
    input  logic            reset,
    joy_db15_scan_if.master joy_io
);

    localparam int unsigned BitW = $clog2(FRAME_BITS);
    localparam int unsigned GapW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    logic                  tick;
    logic [1:0]            sync_q;
    logic                  data_sync;
    state_e                state_q;
    logic                  load_half_q;
    logic [BitW-1:0]       bit_q;
    logic [GapW-1:0]       gap_q;
    logic [FRAME_BITS-1:0] raw_q;
    logic [FRAME_BITS-1:0] prev_q;
    logic                  joy_clk_q;
    logic                  joy_load_q;
    logic [15:0]           joy1_q;
    logic [15:0]           joy2_q;
    logic                  present_q;
    logic                  strobe_q;
    logic                  absent;

    joy_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_i  (clk),
        .rst_i  (reset),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], joy_io.joy_data};
        end
    end

    assign data_sync = sync_q[1];
    // A data line stuck low reads as every button pressed: no adapter attached.
    assign absent    = &raw_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StLoad;
            load_half_q <= 1'b0;
            bit_q       <= '0;
            gap_q       <= '0;
            raw_q       <= '0;
            prev_q      <= '0;
            joy_clk_q   <= 1'b0;
            joy_load_q  <= 1'b1;
            joy1_q      <= '0;
            joy2_q      <= '0;
            present_q   <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            unique case (state_q)
                StLoad: begin
                    if (tick) begin
                        if (!load_half_q) begin
                            load_half_q <= 1'b1;
                            joy_load_q  <= 1'b0;
                        end else begin
                            load_half_q <= 1'b0;
                            joy_load_q  <= 1'b1;
                            bit_q       <= '0;
                            state_q     <= StShiftLo;
                        end
                    end
                end
                StShiftLo: begin
                    if (tick) begin
                        raw_q[bit_q] <= ~data_sync;
                        if (bit_q == BitW'(FRAME_BITS - 1)) begin
                            state_q <= StDone;
                        end else begin
                            joy_clk_q <= 1'b1;
                            state_q   <= StShiftHi;
                        end
                    end
                end
                StShiftHi: begin
                    if (tick) begin
                        joy_clk_q <= 1'b0;
                        bit_q     <= bit_q + 1'b1;
                        state_q   <= StShiftLo;
                    end
                end
                StDone: begin
                    prev_q  <= raw_q;
                    gap_q   <= '0;
                    state_q <= StGap;
                    if (absent) begin
                        joy1_q    <= '0;
                        joy2_q    <= '0;
                        present_q <= 1'b0;
                        strobe_q  <= 1'b1;
                    end else if ((FILTER == 0) || (raw_q == prev_q)) begin
                        joy1_q    <= pad_word(32'(raw_q), P1_BASE);
                        joy2_q    <= pad_word(32'(raw_q), P2_BASE);
                        present_q <= 1'b1;
                        strobe_q  <= 1'b1;
                    end
                end
                StGap: begin
                    if (tick) begin
                        if (gap_q == GapW'(GAP_TICKS - 1)) begin
                            gap_q      <= '0;
                            joy_load_q <= 1'b0;
                            state_q    <= StLoad;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StLoad;
                end
            endcase
        end
    end

    assign joy_io.joy_clk      = joy_clk_q;
    assign joy_io.joy_load     = joy_load_q;
    assign joy_io.joystick1    = joy1_q;
    assign joy_io.joystick2    = joy2_q;
    assign joy_io.present      = present_q;
    assign joy_io.frame_strobe = strobe_q;

endmodule
